// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus adapter:
// FSM state encoding and the MemStrobe size codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    localparam logic [1:0] STRB_BYTE = 2'b01;
    localparam logic [1:0] STRB_HALF = 2'b10;
    localparam logic [1:0] STRB_WORD = 2'b11;

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: selects the addressed byte/half of a bus word and
// sign- or zero-extends it; words pass through unchanged.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted_s;

    // Lane select and extension; size 00 falls into the word path
    always_comb begin
        shifted_s = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            STRB_BYTE: load_data_o = {{24{~unsigned_i & shifted_s[7]}},  shifted_s[7:0]};
            STRB_HALF: load_data_o = {{16{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
            default:   load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Memory-stage load/store unit: turns one load or store into a req/ack bus
// transaction, stalling the pipeline until it completes or times out.
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_strobe,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_q, load_d;
    logic              err_q, err_d;

    logic              access_s;
    logic              misal_s;
    logic [3:0]        be_s;
    logic [31:0]       rep_s;
    logic              stall_s;
    logic              misalign_s;
    logic [31:0]       fmt_s;

    lsu_load_align u_load_align (
        .rdata_i     (bus_rdata),
        .offset_i    (off_q),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .load_data_o (fmt_s)
    );

    assign access_s = mem_read | mem_write;

    // Byte enables, store-lane replication and alignment check for the request
    always_comb begin
        case (mem_strobe)
            STRB_BYTE: begin
                be_s    = 4'b0001 << addr[1:0];
                rep_s   = {4{wdata[7:0]}};
                misal_s = 1'b0;
            end
            STRB_HALF: begin
                be_s    = 4'b0011 << {addr[1], 1'b0};
                rep_s   = {2{wdata[15:0]}};
                misal_s = addr[0];
            end
            default: begin
                be_s    = 4'b1111;
                rep_s   = wdata;
                misal_s = (addr[1:0] != 2'b00);
            end
        endcase
    end

    // Next-state and combinational outputs of the transaction FSM
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        err_d      = err_q;
        stall_s    = 1'b0;
        misalign_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_s && misal_s) begin
                    misalign_s = 1'b1;
                end else if (access_s) begin
                    stall_s = 1'b1;
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = be_s;
                    wdata_d = mem_write ? rep_s : 32'h0000_0000;
                    off_d   = addr[1:0];
                    size_d  = mem_strobe;
                    uns_d   = load_unsigned;
                    cnt_d   = '0;
                    load_d  = 32'h0000_0000;
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                // Ack is checked first so a same-cycle ack beats the timeout
                if (bus_ack || ((TIMEOUT != 0) && (cnt_q == CNT_LIM))) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0000_0000;
                    be_d    = 4'b0000;
                    wdata_d = 32'h0000_0000;
                    cnt_d   = '0;
                    load_d  = (bus_ack && !we_q) ? fmt_s : 32'h0000_0000;
                    err_d   = ~bus_ack;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and bus-field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            load_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign load_data = load_q;
    assign bus_err   = err_q;
    assign misalign  = misalign_s;
    // Held-over pipeline inputs must not keep stall high while in reset
    assign stall     = stall_s & ~rst;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed self-checking bench for lsu_bus_adapter (TIMEOUT=4).
module tb_lsu_bus_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, load_unsigned;
    logic [1:0]  mem_strobe;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we, bus_ack, stall, misalign, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
    logic [3:0]  bus_be;

    int tests_run = 0;
    int tests_failed = 0;

    // results of the last run_access
    int          r_stall, r_req;
    logic [31:0] r_ld, r_addr, r_wd;
    logic        r_err, r_we, r_mis;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    lsu_bus_adapter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_strobe(mem_strobe), .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
        .load_data(load_data), .misalign(misalign), .bus_err(bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one access from IDLE, ack after ack_after ACCESS cycles (-1 = never)
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] strb,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_after, input logic [31:0] rdata);
        bit done = 0;
        r_stall = 0; r_req = 0; r_ld = '0; r_err = 0; r_mis = 0;
        r_be = '0; r_addr = '0; r_wd = '0; r_we = 0;
        mem_read = rd; mem_write = wr; mem_strobe = strb; load_unsigned = uns;
        addr = a; wdata = wd;
        for (int it = 0; it < 40 && !done; it++) begin
            #1;
            if (misalign) r_mis = 1'b1;
            if (stall) r_stall++;
            if (bus_req) begin
                r_be = bus_be; r_addr = bus_addr; r_wd = bus_wdata; r_we = bus_we;
                bus_ack = (r_req == ack_after);
                bus_rdata = rdata;
                r_req++;
            end else begin
                bus_ack = 1'b0;
            end
            if (!stall && (r_stall > 0 || misalign)) begin
                r_ld = load_data; r_err = bus_err; done = 1;
                mem_read = 1'b0; mem_write = 1'b0;
            end
            tick();
        end
        bus_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL completion: access at %h never finished (got stall cycles %0d, want finish)", a, r_stall);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_read = 0; mem_write = 0; mem_strobe = 2'b00; load_unsigned = 0;
        addr = '0; wdata = '0; bus_ack = 0; bus_rdata = '0;
        tick();
        tests_run++;
        if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, stall, misalign, bus_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req=%b we=%b be=%b addr=%h wd=%h ld=%h stall=%b, want all 0",
                     bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, stall);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_noaccess: stall=%b req=%b, want 0 0", stall, bus_req);
        end
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0);
        tests_run++;
        if (r_addr !== 32'h1000 || r_be !== 4'b1000 || r_wd !== 32'hA5A5A5A5 || r_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_bus: addr=%h be=%b wd=%h we=%b, want 00001000 1000 a5a5a5a5 1", r_addr, r_be, r_wd, r_we);
        end
        tests_run++;
        if (r_stall !== 2 || r_req !== 1 || r_ld !== 32'h0) begin
            tests_failed++;
            $display("FAIL sb_timing: stall=%0d req=%0d ld=%h, want 2 1 0", r_stall, r_req, r_ld);
        end
        run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1234_ABCD, 0, 32'h0);
        tests_run++;
        if (r_be !== 4'b1100 || r_wd !== 32'hABCDABCD || r_addr !== 32'h4000) begin
            tests_failed++;
            $display("FAIL sh_bus: be=%b wd=%h addr=%h, want 1100 abcdabcd 00004000", r_be, r_wd, r_addr);
        end
        run_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_4008, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF);
        tests_run++;
        if (r_we !== 1'b1 || r_wd !== 32'h0BADF00D || r_ld !== 32'h0) begin
            tests_failed++;
            $display("FAIL rw_priority: we=%b wd=%h ld=%h, want 1 0badf00d 0", r_we, r_wd, r_ld);
        end
    endtask

    task automatic test_loads;
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0, 0, 32'h0000_80FF);
        tests_run++;
        if (r_ld !== 32'hFFFFFF80 || r_be !== 4'b0010 || r_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb: ld=%h be=%b we=%b, want ffffff80 0010 0", r_ld, r_be, r_we);
        end
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2001, 32'h0, 0, 32'h0000_80FF);
        tests_run++;
        if (r_ld !== 32'h00000080) begin
            tests_failed++;
            $display("FAIL lbu: ld=%h, want 00000080", r_ld);
        end
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
        tests_run++;
        if (r_ld !== 32'hFFFF8001 || r_be !== 4'b1100 || r_addr !== 32'h2000) begin
            tests_failed++;
            $display("FAIL lh: ld=%h be=%b addr=%h, want ffff8001 1100 00002000", r_ld, r_be, r_addr);
        end
        run_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_2000, 32'h0, 0, 32'h8001_9234);
        tests_run++;
        if (r_ld !== 32'h00009234) begin
            tests_failed++;
            $display("FAIL lhu: ld=%h, want 00009234", r_ld);
        end
        run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_2000, 32'h0, 2, 32'hDEAD_BEEF);
        tests_run++;
        if (r_ld !== 32'hDEADBEEF || r_stall !== 4 || r_req !== 3 || r_be !== 4'b1111 || r_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL lw_delay: ld=%h stall=%0d req=%0d be=%b err=%b, want deadbeef 4 3 1111 0",
                     r_ld, r_stall, r_req, r_be, r_err);
        end
    endtask

    task automatic test_misalign;
        run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_3002, 32'h0, 0, 32'h0);
        tests_run++;
        if (r_mis !== 1'b1 || r_req !== 0 || r_stall !== 0) begin
            tests_failed++;
            $display("FAIL mis_lw: mis=%b req=%0d stall=%0d, want 1 0 0", r_mis, r_req, r_stall);
        end
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0);
        tests_run++;
        if (r_mis !== 1'b1 || r_req !== 0 || r_stall !== 0) begin
            tests_failed++;
            $display("FAIL mis_lh: mis=%b req=%0d stall=%0d, want 1 0 0", r_mis, r_req, r_stall);
        end
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0, 0, 32'h0);
        tests_run++;
        if (r_mis !== 1'b1 || r_req !== 0) begin
            tests_failed++;
            $display("FAIL mis_strb00: mis=%b req=%0d, want 1 0", r_mis, r_req);
        end
        tests_run++;
        if (bus_req !== 1'b0 || misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_after: req=%b mis=%b, want 0 0", bus_req, misalign);
        end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0, -1, 32'h1234_5678);
        tests_run++;
        if (r_req !== 4 || r_stall !== 5 || r_err !== 1'b1 || r_ld !== 32'h0) begin
            tests_failed++;
            $display("FAIL timeout: req=%0d stall=%0d err=%b ld=%h, want 4 5 1 0", r_req, r_stall, r_err, r_ld);
        end
        tests_run++;
        if (bus_err !== 1'b0 || bus_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_pulse: err=%b req=%b after DONE, want 0 0", bus_err, bus_req);
        end
        run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_6000, 32'h0, 3, 32'h1234_5678);
        tests_run++;
        if (r_req !== 4 || r_err !== 1'b0 || r_ld !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL ack_wins: req=%0d err=%b ld=%h, want 4 0 12345678", r_req, r_err, r_ld);
        end
    endtask

    task automatic test_reset_mid;
        mem_write = 1'b1; mem_read = 1'b0; mem_strobe = 2'b11; addr = 32'h0000_7004; wdata = 32'h5555_AAAA;
        tick();
        tests_run++;
        if (bus_req !== 1'b1 || stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_access: req=%b stall=%b, want 1 1", bus_req, stall);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_drop: req=%b stall=%b, want 0 0", bus_req, stall);
        end
        tick();
        rst = 1'b0; mem_write = 1'b0;
        tick();
        run_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_7008, 32'h0102_0304, 0, 32'h0);
        tests_run++;
        if (r_req !== 1 || r_stall !== 2 || r_addr !== 32'h7008 || r_wd !== 32'h01020304 || r_be !== 4'b1111) begin
            tests_failed++;
            $display("FAIL sw_after_rst: req=%0d stall=%0d addr=%h wd=%h be=%b, want 1 2 00007008 01020304 1111",
                     r_req, r_stall, r_addr, r_wd, r_be);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
